// File: rtl/ascon_phase_ctrl_if.sv
// Signal bundle between the ASCON phase sequencer, its block loader and the
// permutation datapath it steers.
interface ascon_phase_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] ad_blocks;
    logic [CNT_W-1:0] msg_blocks;
    logic             blk_valid;
    logic             blk_ready;
    logic             dp_load_iv;
    logic             dp_round;
    logic [7:0]       dp_rc;
    logic             dp_absorb;
    logic             dp_msg;
    logic             dp_key_init;
    logic             dp_dsep;
    logic             dp_key_final;
    logic             tag_valid;
    logic             busy;

    modport master (
        output start, abort, ad_blocks, msg_blocks, blk_valid,
        input  blk_ready, dp_load_iv, dp_round, dp_rc, dp_absorb, dp_msg,
               dp_key_init, dp_dsep, dp_key_final, tag_valid, busy
    );

    modport slave (
        input  start, abort, ad_blocks, msg_blocks, blk_valid,
        output blk_ready, dp_load_iv, dp_round, dp_rc, dp_absorb, dp_msg,
               dp_key_init, dp_dsep, dp_key_final, tag_valid, busy
    );
endinterface

// File: rtl/ascon_phase_ctrl.sv
// ASCON-128 AEAD phase sequencer: walks init, AD, domain separation, message,
// finalization and tag, driving a one-round-per-cycle permutation datapath.
module ascon_phase_ctrl #(
    parameter int CNT_W = 8
) (
    input logic               wb_clk_i,
    input logic               wb_rst_i,
    ascon_phase_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, LOAD, INIT_P, INIT_K, AD_W, AD_P, DSEP,
        MSG_W, MSG_P, FIN_K, FIN_P, TAG
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;

    logic       live;
    logic       in_wait;
    logic       in_round;
    logic       last_rnd;
    logic       xfer;
    logic [3:0] rc_hi;

    // abort silences every strobe in the very cycle it is seen
    assign live     = ~bus.abort;
    assign in_wait  = (state_q == AD_W) || (state_q == MSG_W);
    assign in_round = (state_q == INIT_P) || (state_q == AD_P) ||
                      (state_q == MSG_P)  || (state_q == FIN_P);
    assign last_rnd = (rnd_q == 4'd11);
    assign rc_hi    = 4'hF - rnd_q;
    assign xfer     = bus.blk_valid & bus.blk_ready;

    assign bus.blk_ready    = in_wait & live;
    assign bus.dp_absorb    = xfer;
    assign bus.dp_msg       = xfer & (state_q == MSG_W);
    assign bus.dp_load_iv   = (state_q == LOAD) & live;
    assign bus.dp_round     = in_round & live;
    assign bus.dp_rc        = bus.dp_round ? {rc_hi, rnd_q} : 8'h00;
    assign bus.dp_key_init  = (state_q == INIT_K) & live;
    assign bus.dp_dsep      = (state_q == DSEP) & live;
    assign bus.dp_key_final = (state_q == FIN_K) & live;
    assign bus.tag_valid    = (state_q == TAG) & live;
    assign bus.busy         = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        ad_cnt_d  = ad_cnt_q;
        msg_cnt_d = msg_cnt_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    ad_cnt_d  = bus.ad_blocks;
                    msg_cnt_d = (bus.msg_blocks == CNT_ZERO) ? CNT_ONE : bus.msg_blocks;
                    state_d   = LOAD;
                end
                LOAD: begin
                    rnd_d   = 4'd0;
                    state_d = INIT_P;
                end
                INIT_P: if (last_rnd) state_d = INIT_K;
                        else          rnd_d   = rnd_q + 4'd1;
                INIT_K: state_d = (ad_cnt_q != CNT_ZERO) ? AD_W : DSEP;
                AD_W: if (xfer) begin
                    rnd_d   = 4'd6;
                    state_d = AD_P;
                end
                AD_P: if (last_rnd) begin
                    ad_cnt_d = ad_cnt_q - CNT_ONE;
                    state_d  = (ad_cnt_q == CNT_ONE) ? DSEP : AD_W;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
                DSEP: state_d = MSG_W;
                // the final message block goes straight to finalization without p6
                MSG_W: if (xfer) begin
                    if (msg_cnt_q == CNT_ONE) begin
                        state_d = FIN_K;
                    end else begin
                        msg_cnt_d = msg_cnt_q - CNT_ONE;
                        rnd_d     = 4'd6;
                        state_d   = MSG_P;
                    end
                end
                MSG_P: if (last_rnd) state_d = MSG_W;
                       else          rnd_d   = rnd_q + 4'd1;
                FIN_K: begin
                    rnd_d   = 4'd0;
                    state_d = FIN_P;
                end
                FIN_P: if (last_rnd) state_d = TAG;
                       else          rnd_d   = rnd_q + 4'd1;
                TAG:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            rnd_q     <= 4'd0;
            ad_cnt_q  <= '0;
            msg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            ad_cnt_q  <= ad_cnt_d;
            msg_cnt_q <= msg_cnt_d;
        end
    end
endmodule

// File: tb/tb_ascon_phase_ctrl.sv
// Randomized bench for ascon_phase_ctrl: expected per-cycle output traces are
// assembled phase by phase from the operation's block counts and stall plan.
module tb_ascon_phase_ctrl;
    localparam int CNT_W = 8;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;

    ascon_phase_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ascon_phase_ctrl #(.CNT_W(CNT_W)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic       blk_ready;
        logic       dp_absorb;
        logic       dp_msg;
        logic       dp_load_iv;
        logic       dp_round;
        logic [7:0] dp_rc;
        logic       dp_key_init;
        logic       dp_dsep;
        logic       dp_key_final;
        logic       tag_valid;
        logic       busy;
    } outs_t;

    outs_t exp_q[$];
    logic  vin_q[$];
    int    total = 0;
    int    bad   = 0;

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic outs_t busy_only();
        outs_t o;
        o      = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic outs_t observe();
        outs_t o;
        o.blk_ready    = bus.blk_ready;
        o.dp_absorb    = bus.dp_absorb;
        o.dp_msg       = bus.dp_msg;
        o.dp_load_iv   = bus.dp_load_iv;
        o.dp_round     = bus.dp_round;
        o.dp_rc        = bus.dp_rc;
        o.dp_key_init  = bus.dp_key_init;
        o.dp_dsep      = bus.dp_dsep;
        o.dp_key_final = bus.dp_key_final;
        o.tag_valid    = bus.tag_valid;
        o.busy         = bus.busy;
        return o;
    endfunction

    task automatic check(input string tag, input int idx, input outs_t got, input outs_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s idx=%0d observed=%h expected=%h", tag, idx, got, exp);
        end
    endtask

    task automatic push(input outs_t o, input logic v);
        exp_q.push_back(o);
        vin_q.push_back(v);
    endtask

    // round i carries constant (15-i)*16 + i
    task automatic add_rounds(input int first);
        outs_t o;
        for (int i = first; i < 12; i++) begin
            o          = busy_only();
            o.dp_round = 1'b1;
            o.dp_rc    = 8'((15 - i) * 16 + i);
            push(o, rbit());
        end
    endtask

    task automatic add_block(input logic is_msg, input int stalls);
        outs_t o;
        for (int s = 0; s < stalls; s++) begin
            o           = busy_only();
            o.blk_ready = 1'b1;
            push(o, 1'b0);
        end
        o           = busy_only();
        o.blk_ready = 1'b1;
        o.dp_absorb = 1'b1;
        o.dp_msg    = is_msg;
        push(o, 1'b1);
    endtask

    task automatic build(input int ad, input int msg, input int max_stall, input int first_msg_stall);
        outs_t o;
        int    n_msg;
        int    st;
        exp_q.delete();
        vin_q.delete();
        n_msg = (msg == 0) ? 1 : msg;
        o = busy_only(); o.dp_load_iv = 1'b1; push(o, rbit());
        add_rounds(0);
        o = busy_only(); o.dp_key_init = 1'b1; push(o, rbit());
        for (int b = 0; b < ad; b++) begin
            add_block(1'b0, $urandom_range(max_stall, 0));
            add_rounds(6);
        end
        o = busy_only(); o.dp_dsep = 1'b1; push(o, rbit());
        for (int b = 0; b < n_msg; b++) begin
            st = (b == 0 && first_msg_stall >= 0) ? first_msg_stall : $urandom_range(max_stall, 0);
            add_block(1'b1, st);
            if (b != n_msg - 1) add_rounds(6);
        end
        o = busy_only(); o.dp_key_final = 1'b1; push(o, rbit());
        add_rounds(0);
        o = busy_only(); o.tag_valid = 1'b1; push(o, rbit());
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_op(input int ad, input int msg, input int max_stall, input int first_stall,
                          input int abort_at, input int rst_at, input int start_at, input string name);
        outs_t e;
        build(ad, msg, max_stall, first_stall);
        bus.start      = 1'b1;
        bus.abort      = 1'b0;
        bus.ad_blocks  = CNT_W'(ad);
        bus.msg_blocks = CNT_W'(msg);
        bus.blk_valid  = rbit();
        @(posedge wb_clk_i); #1;
        bus.start      = 1'b0;
        bus.ad_blocks  = CNT_W'($urandom);
        bus.msg_blocks = CNT_W'($urandom);
        for (int k = 0; k < exp_q.size(); k++) begin
            e             = exp_q[k];
            bus.blk_valid = vin_q[k];
            bus.start     = (k == start_at);
            if (k == start_at) begin
                bus.ad_blocks  = CNT_W'($urandom);
                bus.msg_blocks = CNT_W'($urandom);
            end
            if (k == abort_at) begin
                bus.abort = 1'b1;
                e         = busy_only();
            end
            if (k == rst_at) begin
                #2 wb_rst_i = 1'b1;
                #1 check({name, "_rst"}, k, observe(), '0);
                @(posedge wb_clk_i); #1;
                wb_rst_i = 1'b0;
                break;
            end
            @(negedge wb_clk_i);
            check(name, k, observe(), e);
            @(posedge wb_clk_i); #1;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            if (k == abort_at) break;
        end
        bus.blk_valid = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        @(negedge wb_clk_i);
        check({name, "_idle"}, -1, observe(), '0);
        @(posedge wb_clk_i); #1;
    endtask

    initial begin
        int ab;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.ad_blocks  = '0;
        bus.msg_blocks = '0;
        bus.blk_valid  = 1'b1;
        @(negedge wb_clk_i);
        check("reset", 0, observe(), '0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("post_reset", 0, observe(), '0);
        @(posedge wb_clk_i); #1;

        run_op(0, 1, 0, -1, -1, -1, -1, "ad0_msg1");
        run_op(1, 2, 0, -1, -1, -1, -1, "ad1_msg2");
        run_op(1, 2, 0, 3, -1, -1, -1, "msg_stall3");
        run_op(0, 1, 0, -1, 5, -1, -1, "abort_init");
        run_op(0, 1, 0, -1, -1, -1, -1, "after_abort");
        run_op(1, 2, 0, -1, -1, -1, 10, "start_ignored");
        run_op(2, 1, 0, -1, -1, 17, -1, "rst_adp");
        run_op(2, 0, 1, -1, -1, -1, -1, "msg0");
        run_op(2, 1, 1, -1, -1, -1, -1, "msg1");

        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.ad_blocks  = 8'd1;
        bus.msg_blocks = 8'd1;
        @(posedge wb_clk_i); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge wb_clk_i);
        check("abort_beats_start", 0, observe(), '0);
        @(posedge wb_clk_i); #1;

        run_op(255, 1, 0, -1, -1, -1, -1, "ad_max");

        for (int n = 0; n < 25; n++) begin
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 0)) : -1;
            run_op($urandom_range(4, 0), $urandom_range(4, 0), 2, -1, ab, -1, -1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
